// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the wide instruction memory.
// Optional build macro: INSTR_MEM_CLEAR_ON_RESET_EN adds the CLEAR state.
package instr_mem_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_FETCH_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
    ,
    CLEAR  = 2'd2
`endif
  } state_t;

  // Ceiling log2 for elaboration-time sizing (exact for powers of two).
  function automatic int unsigned log2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < v; i = i * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// One byte lane of the instruction memory: single port, synchronous
// write, registered read. The read register only updates on re so it
// keeps the last word read between fetches.
module instr_mem_bank #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Single shared port: a write takes priority over a read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_mem_wide.sv
// Byte-addressed instruction memory with a FETCH_BYTES-wide little-endian
// fetch port (misaligned fetches take two reads) and a strobed word write
// port. Optional build macro: INSTR_MEM_CLEAR_ON_RESET_EN zeroes the whole
// array, one word per cycle, after every reset.
module instr_mem_wide
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned FETCH_BYTES = DEF_FETCH_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [8*FETCH_BYTES-1:0] fetch_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [8*FETCH_BYTES-1:0] wr_data,
  input  logic [FETCH_BYTES-1:0]   wr_strb,
  output logic                     wr_ack
);

  localparam int unsigned LG = log2_u(FETCH_BYTES);
  localparam int unsigned WA = ADDR_W - LG;
  localparam int unsigned DW = 8 * FETCH_BYTES;

`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_nxt;

  logic [WA-1:0]          fetch_word;
  logic [WA-1:0]          nxt_word_q, nxt_word_d;
  logic [LG-1:0]          off_q, off_d;
  logic                   valid_q, valid_d;
  logic                   hold_ld;
  logic [DW-1:0]          hold_q;
  logic [DW-1:0]          last_q;

  logic [WA-1:0]          bank_addr;
  logic                   bank_re;
  logic [FETCH_BYTES-1:0] bank_we;
  logic [DW-1:0]          bank_wdata;
  logic [DW-1:0]          bank_rdata;

  logic [2*DW-1:0]        pair;
  logic [2*DW-1:0]        shifted;
  logic [DW-1:0]          assembled;

`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
  logic [WA-1:0]          clr_cnt, clr_cnt_d;
`endif

  logic unused_wr_lo;
  assign unused_wr_lo = ^wr_addr[LG-1:0];

  assign fetch_word  = fetch_addr[ADDR_W-1:LG];
  assign fetch_valid = valid_q;

  // Byte-lane banks, all sharing one word address.
  for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_lane
    instr_mem_bank #(.AW(WA)) u_bank (
      .clk   (clk),
      .we    (bank_we[i]),
      .re    (bank_re),
      .addr  (bank_addr),
      .wdata (bank_wdata[8*i +: 8]),
      .rdata (bank_rdata[8*i +: 8])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshakes and bank port steering.
  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    wr_ack      = 1'b0;
    hold_ld     = 1'b0;
    bank_addr   = fetch_word;
    bank_re     = 1'b0;
    bank_we     = '0;
    bank_wdata  = wr_data;
    nxt_word_d  = nxt_word_q;
    off_d       = off_q;
    valid_d     = 1'b0;
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
    clr_cnt_d   = clr_cnt;
`endif
    unique case (state)
      IDLE: begin
        fetch_ready = rst && !wr_en;
        wr_ack      = rst && wr_en;
        if (wr_ack) begin
          bank_addr = wr_addr[ADDR_W-1:LG];
          bank_we   = wr_strb;
        end else if (fetch_ready && fetch_req) begin
          bank_re    = 1'b1;
          off_d      = fetch_addr[LG-1:0];
          nxt_word_d = fetch_word + WA'(1);
          if (fetch_addr[LG-1:0] == '0) begin
            valid_d = 1'b1;
          end else begin
            state_nxt = SECOND;
          end
        end
      end
      SECOND: begin
        bank_addr = nxt_word_q;
        bank_re   = 1'b1;
        hold_ld   = 1'b1;
        valid_d   = 1'b1;
        state_nxt = IDLE;
      end
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
      CLEAR: begin
        bank_addr  = clr_cnt;
        bank_wdata = '0;
        bank_we    = rst ? '1 : '0;
        clr_cnt_d  = clr_cnt + WA'(1);
        if (clr_cnt == '1) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch bookkeeping, hold register and last-output capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      off_q      <= '0;
      nxt_word_q <= '0;
      hold_q     <= '0;
      last_q     <= '0;
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
      clr_cnt    <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      off_q      <= off_d;
      nxt_word_q <= nxt_word_d;
      if (hold_ld) begin
        hold_q <= bank_rdata;
      end
      if (valid_q) begin
        last_q <= fetch_data;
      end
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
      clr_cnt    <= clr_cnt_d;
`endif
    end
  end

  // Lane rotate: the hold word supplies lanes o.. of the result and the
  // second word fills the top; the bank read register itself is the
  // pipeline stage, and last_q keeps the output stable between pulses.
  always_comb begin
    pair      = {bank_rdata, hold_q};
    shifted   = pair >> {off_q, 3'b000};
    assembled = (off_q == '0) ? bank_rdata : shifted[DW-1:0];
    fetch_data = valid_q ? assembled : last_q;
  end

endmodule

// File: tb/tb_instr_mem_wide.sv
// Self-checking bench for instr_mem_wide (ADDR_W=8, FETCH_BYTES=4).
// Honours INSTR_MEM_CLEAR_ON_RESET_EN when built with it.
module tb_instr_mem_wide;

  localparam int unsigned AW = 8;
  localparam int unsigned FB = 4;
  localparam int unsigned DW = 32;
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
  localparam int unsigned CLR_CYCLES = 64;
`else
  localparam int unsigned CLR_CYCLES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [FB-1:0] wr_strb = '0;
  logic          wr_ack;

  always #5 clk = ~clk;

  instr_mem_wide #(.ADDR_W(AW), .FETCH_BYTES(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_ack      (wr_ack)
  );

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  logic [7:0]  model[256];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic sample();
    exp_t e;
    if (fetch_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'b0, fetch_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("fetch_data", fetch_data, e.data);
        check("fetch_latency", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("missing_valid", {31'b0, fetch_valid}, 32'd1);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [7:0] base;
    base = {a[7:2], 2'b00};
    for (int j = 0; j < 4; j++) begin
      if (s[j]) model[base + 8'(j)] = d[8*j +: 8];
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [7:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = model[a + 8'(j)];
    return r;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    #1 check("wr_ack", {31'b0, wr_ack}, 32'd1);
    clk_cycle();
    wr_en = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [31:0] exp, input int unsigned lat);
    exp_t e;
    fetch_req = 1'b1; fetch_addr = a;
    #1 check("fetch_ready", {31'b0, fetch_ready}, 32'd1);
    e.data = exp; e.due = cyc + lat;
    sb.push_back(e);
    clk_cycle();
    fetch_req = 1'b0;
    if (lat == 2) begin
      #1 check("ready_in_second", {31'b0, fetch_ready}, 32'd0);
      clk_cycle();
    end
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    #1;
    while (fetch_ready !== 1'b1 && n < 200) begin
      clk_cycle();
      #1;
      n++;
    end
    check("cycles_to_ready", n, CLR_CYCLES);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    vecs[0]  = '{1'b1, 8'h00, 32'h44332211, 4'hF, 32'h0, 0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h44332211, 1};
    vecs[2]  = '{1'b1, 8'h04, 32'h88776655, 4'hF, 32'h0, 0};
    vecs[3]  = '{1'b0, 8'h02, 32'h0, 4'h0, 32'h66554433, 2};
    vecs[4]  = '{1'b1, 8'hFC, 32'hDDCCBBAA, 4'hF, 32'h0, 0};
    vecs[5]  = '{1'b0, 8'hFE, 32'h0, 4'h0, 32'h2211DDCC, 2};
    vecs[6]  = '{1'b0, 8'hFC, 32'h0, 4'h0, 32'hDDCCBBAA, 1};
    vecs[7]  = '{1'b0, 8'h01, 32'h0, 4'h0, 32'h55443322, 2};
    vecs[8]  = '{1'b0, 8'h03, 32'h0, 4'h0, 32'h77665544, 2};
    vecs[9]  = '{1'b1, 8'h03, 32'h0000AA00, 4'h2, 32'h0, 0};
    vecs[10] = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h4433AA11, 1};
    vecs[11] = '{1'b0, 8'hFF, 32'h0, 4'h0, 32'h33AA11DD, 2};
    vecs[12] = '{1'b0, 8'h04, 32'h0, 4'h0, 32'h88776655, 1};

    foreach (model[i]) model[i] = 8'h00;

    // Reset: no handshakes while rst is low.
    repeat (3) clk_cycle();
    wr_en = 1'b1;
    #1 check("wr_ack_in_reset", {31'b0, wr_ack}, 32'd0);
    check("ready_in_reset", {31'b0, fetch_ready}, 32'd0);
    wr_en = 1'b0;
    rst = 1'b1;
    wait_ready();
    check("reset_valid", {31'b0, fetch_valid}, 32'd0);
    check("reset_data", fetch_data, 32'd0);

`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
    do_fetch(8'h00, 32'h0, 1);
    do_fetch(8'h7D, 32'h0, 2);
`endif

    // Fill the array so every later fetch has defined contents.
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      do_write(8'(w * 4), d, 4'hF);
    end

    // Directed table.
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else do_fetch(vecs[i].addr, vecs[i].exp, vecs[i].lat);
    end

    // Write and fetch together: write wins, fetch retried next cycle.
    wr_en = 1'b1; wr_addr = 8'h08; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
    fetch_req = 1'b1; fetch_addr = 8'h08;
    #1 check("wr_ack_collide", {31'b0, wr_ack}, 32'd1);
    check("ready_collide", {31'b0, fetch_ready}, 32'd0);
    clk_cycle();
    wr_en = 1'b0;
    fetch_req = 1'b0;
    model_write(8'h08, 32'hCAFEF00D, 4'hF);
    do_fetch(8'h08, 32'hCAFEF00D, 1);

    // Random mix, expectations from the byte model.
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        s = 4'($urandom);
        do_write(a, d, s);
      end else begin
        do_fetch(a, model_fetch(a), (a[1:0] != 2'b00) ? 2 : 1);
      end
    end

    // Reset while a misaligned fetch is in SECOND: the fetch is dropped.
    fetch_req = 1'b1; fetch_addr = 8'h02;
    clk_cycle();
    fetch_req = 1'b0;
    rst = 1'b0;
    clk_cycle();
    check("drop_valid", {31'b0, fetch_valid}, 32'd0);
    #1 check("ready_in_reset2", {31'b0, fetch_ready}, 32'd0);
    clk_cycle();
    check("drop_valid2", {31'b0, fetch_valid}, 32'd0);
    rst = 1'b1;
`ifdef INSTR_MEM_CLEAR_ON_RESET_EN
    foreach (model[i]) model[i] = 8'h00;
`endif
    wait_ready();
    check("post_reset_data", fetch_data, 32'd0);
    check("post_reset_valid", {31'b0, fetch_valid}, 32'd0);
    do_fetch(8'h04, model_fetch(8'h04), 1);
    do_fetch(8'hFD, model_fetch(8'hFD), 2);

    repeat (4) clk_cycle();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_wide.md
# instr_mem_wide

Parametrised byte-addressed instruction memory that replaces the 64x8 single-byte instruction store. It has a FETCH_BYTES-wide little-endian fetch port with a ready/valid handshake and misaligned-fetch support, plus a strobed word write port for the program loader. The memory is organised as FETCH_BYTES byte-lane banks. It sits between the loader/debug write path and the core's fetch stage.

## Interface
- ADDR_W, default 8: byte address width; capacity is 2^ADDR_W bytes.
- FETCH_BYTES, default 4: bytes per fetch/write word; power of two, at least 2.
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, synchronous and active-low.
- fetch_req  in  1: fetch request.
- fetch_addr  in  ADDR_W: byte address of the first fetched byte; any alignment allowed.
- fetch_ready  out  1: fetch can be accepted this cycle.
- fetch_valid  out  1: one-cycle pulse; fetch_data is valid.
- fetch_data  out  8*FETCH_BYTES: fetched bytes, little-endian (byte at fetch_addr in bits [7:0]).
- wr_en  in  1: write request.
- wr_addr  in  ADDR_W: write address; low log2(FETCH_BYTES) bits are ignored (word-aligned).
- wr_data  in  8*FETCH_BYTES: write data.
- wr_strb  in  FETCH_BYTES: per-byte write enables.
- wr_ack  out  1: write accepted this cycle.

## Operation
- States:
  - IDLE: accepts fetches and writes.
  - SECOND: second word read for a misaligned fetch.
  - CLEAR: only present when the Configuration macro is defined.
- Readiness:
  - fetch_ready = (state==IDLE) && !wr_en.
  - wr_ack = wr_en && (state==IDLE).
- A write and a fetch requested in the same cycle: the write wins and the fetch is not accepted; the requester retries.
- Accepted write: lane i is written with wr_data[8i+7:8i] only where wr_strb[i]=1. All other bytes are unchanged.
- Aligned fetch (offset o = fetch_addr[log2(FETCH_BYTES)-1:0] = 0): reads word k = fetch_addr>>log2(FETCH_BYTES); state stays IDLE.
- Misaligned fetch (o != 0):
  - Cycle 1 reads word k. The next cycle latches lanes o..FETCH_BYTES-1 of word k into a hold register and reads word k+1; state goes to SECOND.
  - The result is assembled from the hold lanes plus lanes 0..o-1 of word k+1; state returns to IDLE.
- Address wrap: k+1 wraps modulo 2^(ADDR_W-log2(FETCH_BYTES)). A fetch at the top word continues at byte 0.
- Read-during-write to the same address cannot occur, because a write blocks fetch acceptance. A fetch accepted the cycle after a write returns the new data.
- Reset (rst=0 at a clock edge) from any state, including SECOND:
  - State goes to IDLE, or to CLEAR with the macro defined.
  - fetch_valid=0, fetch_data=0, hold register cleared; an in-flight fetch is dropped with no valid pulse.
  - fetch_ready=0 and wr_ack=0 while rst=0.
- Without the macro, memory contents are not affected by reset.

## Timing
- Aligned fetch accepted at edge T: fetch_valid=1 and fetch_data valid during the cycle after T (latency 1). A new fetch can be accepted at T+1, giving one fetch per cycle.
- Misaligned fetch accepted at edge T: state=SECOND after T and fetch_ready=0. fetch_valid pulses in the cycle after T+1 (latency 2); the next accept is possible at T+2.
- fetch_valid is high for exactly one cycle per accepted fetch. There is no backpressure; the consumer must capture the data.
- fetch_data holds its last value when fetch_valid=0.
- Write accepted at edge T: the data is visible to a fetch accepted at T+1.
- wr_ack is combinational from wr_en and state.

## Configuration
- INSTR_MEM_CLEAR_ON_RESET_EN defined:
  - Leaving reset enters CLEAR, which zeroes one word per cycle from word 0 upward.
  - fetch_ready=0 and wr_ack=0 throughout CLEAR.
  - Goes to IDLE after 2^ADDR_W/FETCH_BYTES cycles.
  - Reset asserted during CLEAR restarts the sweep from word 0.
- Not defined: the CLEAR state and counter are absent, and the block is in IDLE on the first cycle after rst deasserts.

## Structure
- Package instr_mem_pkg holds:
  - state encoding (IDLE, SECOND, CLEAR);
  - a log2 helper function;
  - default ADDR_W/FETCH_BYTES constants.
- Sub-module instr_mem_bank is instantiated FETCH_BYTES times:
  - one byte lane of depth 2^ADDR_W/FETCH_BYTES;
  - single port; synchronous write enable; registered read.
- The top level holds the FSM, the hold register, the lane rotate/assemble mux and the clear counter.

## Test plan
- Write word 0x0000 with data 0x44332211, strb 0xF, then fetch addr 0x00 -> one cycle later fetch_valid=1, fetch_data=0x44332211.
- Write word 0x04 with 0x88776655, then fetch addr 0x02 -> fetch_ready low for one cycle; valid 2 cycles after accept; data=0x66554433.
- Fill the top word 0xFC with 0xDDCCBBAA and word 0 with 0x44332211, then fetch addr 0xFE -> data=0x2211DDCC (wraps to byte 0).
- Assert wr_en and fetch_req together -> wr_ack=1, fetch_ready=0. The fetch is accepted next cycle and returns the newly written data. Writing with strb=0x2 changes only byte 1.
- Accept a misaligned fetch, then pull rst low in SECOND -> no fetch_valid pulse; after release, outputs are 0 and an aligned fetch works normally.
- With INSTR_MEM_CLEAR_ON_RESET_EN defined: after reset, fetch_ready stays low for 64 cycles (ADDR_W=8). A subsequent fetch of any address returns 0.
